quad_decoder: RTL
=================

# quad_decoder

Quadrature decoder that turns two asynchronous phase inputs (A/B, e.g. from a rotary encoder) into the `enable`/`up_down` step stream consumed by `n_counter`. It synchronises and glitch-filters both phases, decodes the Gray-code sequence into single-cycle step pulses with a direction level, and flags and counts illegal transitions. It sits between the board pins and the position counter: `step` drives the counter's `enable` and `dir` drives its `up_down`.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops per phase input; legal values 2..4.
- `FILTER_LEN`, 4: consecutive cycles a synchronised phase must differ from its filtered value before the filtered value changes; legal values 1..16. Filter counter width is `CLogB2(FILTER_LEN)+1`.
- `ERR_W`, 8: width of the error counter.
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `en`  input  1  decode enable; when low, `step` and `err` are forced to 0 while state tracking continues.
- `a_in`  input  1  phase A, asynchronous.
- `b_in`  input  1  phase B, asynchronous.
- `err_clr`  input  1  synchronous clear of `err_count`.
- `step`  output  1  one-cycle pulse per legal quadrature transition.
- `dir`  output  1  direction of the last legal step: 1 = up, 0 = down.
- `err`  output  1  one-cycle pulse on an illegal transition, where both filtered phases change together.
- `err_count`  output  `ERR_W`  saturating count of illegal transitions.

## Operation
- Reset values: all synchroniser flops 0, filter counters 0, filtered phases 00, previous state 00, FSM = INIT, `step`=0, `err`=0, `dir`=1, `err_count`=0.
- FSM has two states.
  - **INIT**: an init counter runs for `SYNC_STAGES` cycles after reset deasserts.
  - At the next edge, the filtered phases and the previous state are loaded directly from the synchronised inputs, with no step and no error, and the FSM goes to RUN.
  - The FSM never returns to INIT except through reset.
- **Filter**, per phase, in RUN:
  - If the synchronised value equals the filtered value, the counter is cleared to 0.
  - Otherwise the counter increments.
  - When it reaches `FILTER_LEN`, the filtered value toggles and the counter clears.
  - A glitch shorter than `FILTER_LEN` cycles is fully rejected.
- **Decode** compares the previous state {A,B} with the current filtered state {A,B} each cycle, then sets previous ← current.
  - Up sequence: 00→01→11→10→00. Each such transition gives `step`=1, `dir`=1.
  - Down sequence: 00→10→11→01→00. Each such transition gives `step`=1, `dir`=0.
  - No change: `step`=0 and `dir` holds.
  - Both bits change: `err`=1, `step`=0, `dir` holds, and `err_count` increments, saturating at 2^`ERR_W`−1.
- **`en` low**: `step` and `err` are 0 and `err_count` does not increment. Filter and previous state keep updating, so re-enabling never produces a stale step.
- **`err_clr`**: `err_count` ← 0 on the next edge. It overrides a simultaneous increment, so that error is dropped from the count; the `err` pulse still occurs.
- `step`, `dir`, `err` and `err_count` are registered outputs, with no combinational path from any input.

## Timing
- Latency: a phase change that is stable before edge 1 is captured by sync stage 1 at edge 1.
  - The synchronised value is visible after edge `SYNC_STAGES`.
  - The filtered value toggles at edge `SYNC_STAGES`+`FILTER_LEN`.
  - `step`/`err` is high for exactly the cycle after edge `SYNC_STAGES`+`FILTER_LEN`+1. With defaults this is 7 edges.
- Maximum step rate: one filtered transition per `FILTER_LEN` cycles per phase. Phase edges closer together than `FILTER_LEN`+1 cycles may be merged into an illegal transition; this is the specified behaviour.
- `step` and `err` are never high in the same cycle.
- Asserting `reset` mid-operation immediately forces all outputs to their reset values, with no pending pulse; decode restarts from INIT.

## Test plan
- **Reset/init**: hold `a_in`=1, `b_in`=1 through reset, release, and wait 10 cycles → `step`=0, `err`=0, `err_count`=0, `dir`=1; FSM in RUN with filtered state 11.
- **Forward rotation**: from 00, drive 01, 11, 10, 00, each held 10 cycles → 4 `step` pulses. Each pulse is 1 cycle wide and lands 7 cycles after its input change; `dir`=1 throughout.
- **Reverse then forward**: from 00, drive 10, 11, then 10, 00 → 4 steps. `dir`=0 for the first two, then `dir`=1 starting with the third step.
- **Glitch rejection**: hold 00 and pulse `a_in` high for 3 cycles (`FILTER_LEN`=4) → no `step`, no `err`. A 4-cycle pulse → a step up followed by a step down.
- **Illegal transition**: from 00, switch both inputs to 11 on the same edge → one `err` pulse, `err_count`=1, no `step`. Repeating 300 times with `ERR_W`=8 → `err_count` saturates at 255. `err_clr` coincident with an error → `err_count`=0.
- **Enable gating/reset mid-run**: set `en`=0, rotate 2 steps forward, set `en`=1 → no steps during gating and no step on re-enable. Asserting `reset` the cycle before a pending step → no `step` pulse, and all outputs at reset values.

Source files
------------

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters A/B phases, then decodes
// Gray-code transitions into step/dir pulses and counts illegal (double-bit) moves.

module quad_decoder_phase #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic run,
    input  logic raw,
    output logic sync,
    output logic filt
);
    localparam int CW = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            cnt    <= '0;
            filt   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (load) begin
                filt <= sync;
                cnt  <= '0;
            end else if (run) begin
                // any cycle of agreement restarts the qualification window
                if (sync == filt) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    filt <= ~filt;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end
endmodule

module quad_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             err_clr,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic [ERR_W-1:0] err_count
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic [2:0] INIT_LAST = 3'(SYNC_STAGES);

    state_t     state, state_nx;
    logic [2:0] init_cnt;
    logic       load, run;
    logic [1:0] raw, sync, filt, prev;
    logic       up, down, bad;

    assign raw = {a_in, b_in};
    assign run = (state == RUN);

    for (genvar i = 0; i < 2; i++) begin : g_phase
        quad_decoder_phase #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILTER_LEN (FILTER_LEN)
        ) u_phase (
            .clk  (clk),
            .reset(reset),
            .load (load),
            .run  (run),
            .raw  (raw[i]),
            .sync (sync[i]),
            .filt (filt[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT && init_cnt != INIT_LAST)
                init_cnt <= init_cnt + 3'd1;
        end
    end

    // INIT waits for the synchroniser to fill, then adopts its contents as-is
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            INIT: if (init_cnt == INIT_LAST) begin
                load     = 1'b1;
                state_nx = RUN;
            end
            RUN: state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        up   = 1'b0;
        down = 1'b0;
        bad  = ((prev ^ filt) == 2'b11);
        case ({prev, filt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: up   = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: down = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev      <= 2'b00;
            step      <= 1'b0;
            err       <= 1'b0;
            dir       <= 1'b1;
            err_count <= '0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            if (load) begin
                prev <= sync;
            end else if (run) begin
                prev <= filt;
                if (en) begin
                    if (up || down) begin
                        step <= 1'b1;
                        dir  <= up;
                    end else if (bad) begin
                        err <= 1'b1;
                        if (err_count != {ERR_W{1'b1}})
                            err_count <= err_count + ERR_W'(1);
                    end
                end
            end
            // clear wins over a same-cycle increment
            if (err_clr)
                err_count <= '0;
        end
    end
endmodule
